// File: rtl/res_ram_arbiter.sv
// Two-requester round-robin arbiter for the single res_RAM port.
// Define RES_ARB_LOCK_EN to enable ownership locking (lock0/lock1).
module res_ram_arbiter #(
   parameter int AW       = 14,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          lock0,
   input  logic          lock1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          res_rd,
   output logic          res_wr,
   output logic [AW-1:0] res_addr,
   output logic [DW-1:0] res_do,
   input  logic [DW-1:0] res_di,
   output logic          busy
);

   logic          res_rd_q, res_wr_q;
   logic          rv0_q, rv1_q;
   logic          tag_q, rr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] do_q, rdata_q;
   logic          in_lock0, in_lock1;

`ifdef RES_ARB_LOCK_EN
   typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;
   localparam int CW = $clog2(LOCK_MAX + 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          cnt_hit;

   assign in_lock0 = (state_q == LOCK0);
   assign in_lock1 = (state_q == LOCK1);
   assign cnt_hit  = (cnt_q == CW'(LOCK_MAX - 1));

   // Leaving a lock hands priority to the requester that was shut out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
      end else begin
         case (state_q)
            LOCK0: begin
               if (cnt_q != CW'(LOCK_MAX)) cnt_q <= cnt_q + 1'b1;
               if ((gnt0 & ~lock0) | ~req0 | cnt_hit) begin
                  state_q <= ARB;
                  rr_q    <= 1'b1;
               end
            end
            LOCK1: begin
               if (cnt_q != CW'(LOCK_MAX)) cnt_q <= cnt_q + 1'b1;
               if ((gnt1 & ~lock1) | ~req1 | cnt_hit) begin
                  state_q <= ARB;
                  rr_q    <= 1'b0;
               end
            end
            default: begin
               if (gnt0) begin
                  rr_q <= 1'b1;
                  if (lock0) begin
                     state_q <= LOCK0;
                     cnt_q   <= '0;
                  end
               end else if (gnt1) begin
                  rr_q <= 1'b0;
                  if (lock1) begin
                     state_q <= LOCK1;
                     cnt_q   <= '0;
                  end
               end
            end
         endcase
      end
   end
`else
   logic unused_lock;

   assign in_lock0    = 1'b0;
   assign in_lock1    = 1'b0;
   assign unused_lock = lock0 | lock1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q <= 1'b0;
      end else if (gnt0) begin
         rr_q <= 1'b1;
      end else if (gnt1) begin
         rr_q <= 1'b0;
      end
   end
`endif

   assign gnt0 = reset & req0 & ~in_lock1 &
                 (in_lock0 | ~req1 | ~rr_q);
   assign gnt1 = reset & req1 & ~in_lock0 &
                 (in_lock1 | ~req0 | rr_q);

   // tag_q remembers which requester owns the read now at the RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_rd_q <= 1'b0;
         res_wr_q <= 1'b0;
         addr_q   <= '0;
         do_q     <= '0;
         tag_q    <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         res_rd_q <= 1'b0;
         res_wr_q <= 1'b0;
         if (gnt0) begin
            addr_q   <= addr0;
            do_q     <= wdata0;
            res_wr_q <= we0;
            res_rd_q <= ~we0;
            tag_q    <= 1'b0;
         end else if (gnt1) begin
            addr_q   <= addr1;
            do_q     <= wdata1;
            res_wr_q <= we1;
            res_rd_q <= ~we1;
            tag_q    <= 1'b1;
         end
         rv0_q <= res_rd_q & ~tag_q;
         rv1_q <= res_rd_q & tag_q;
         if (res_rd_q) rdata_q <= res_di;
      end
   end

   assign res_rd   = res_rd_q;
   assign res_wr   = res_wr_q;
   assign res_addr = addr_q;
   assign res_do   = do_q;
   assign rvalid0  = rv0_q;
   assign rvalid1  = rv1_q;
   assign rdata    = rdata_q;
   assign busy     = res_rd_q | res_wr_q | rv0_q | rv1_q;

endmodule
